// File: rtl/fpu_pkg.sv
// Shared definitions for fpu_mc: opcodes, default float format, FSM states and field helpers.
// The ITER state exists only when FPU_INVF_EN is defined.
package fpu_pkg;

  localparam logic [3:0] OP_INVF = 4'h1;
  localparam logic [3:0] OP_ADDF = 4'h2;
  localparam logic [3:0] OP_MULF = 4'h3;
  localparam logic [3:0] OP_F2I  = 4'hA;
  localparam logic [3:0] OP_I2F  = 4'hB;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 7;
  localparam int BIAS_DEF  = 2**(EXP_W_DEF-1) - 1;

`ifdef FPU_INVF_EN
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_NORM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_NORM, S_DONE} state_t;
`endif

  // Words up to 64 bits; callers zero-extend and truncate the return.
  function automatic logic fld_sign(input logic [63:0] w, input int ew, input int mw);
    return w[ew+mw];
  endfunction

  function automatic logic [63:0] fld_exp(input logic [63:0] w, input int ew, input int mw);
    return (w >> mw) & ((64'd1 << ew) - 64'd1);
  endfunction

  function automatic logic [63:0] fld_man(input logic [63:0] w, input int mw);
    return w & ((64'd1 << mw) - 64'd1);
  endfunction

endpackage

// File: rtl/fpu_mc_lzc.sv
// Leading-zero counter; an all-zero input returns DATA_W.
module fpu_mc_lzc #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]      value,
  output logic [$clog2(DATA_W):0] count
);
  localparam int LZW = $clog2(DATA_W) + 1;

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = LZW'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (value[i]) count = LZW'(DATA_W - 1 - i);
    end
  end
endmodule

// File: rtl/fpu_mc.sv
// Multi-cycle float unit (i2f, f2i, addf, mulf, invf) with valid/ready handshakes, one op in flight.
// Define FPU_INVF_EN to build the restoring divider and ITER state used by invf.
module fpu_mc
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = 2**(EXP_W-1) - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 err
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 1;
  localparam int PW  = 2 * MW;
  localparam int XW  = EXP_W + 4;
  localparam int LZW = $clog2(W) + 1;
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] LIM_X  = XW'(BIAS + W - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'(2**EXP_W - 1);
  localparam logic signed [XW-1:0] W_X    = XW'(W);
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  state_t state, state_nx;

  logic [3:0]   op_p0;
  logic [W-1:0] a_p0, b_p0;

  logic                 sa, sb, za, zb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic [MW-1:0]        ma, mb;
  logic signed [XW-1:0] ea_s, eb_s;
  logic [W-1:0]         ga, gb;

  assign sa   = fld_sign(64'(a_p0), EXP_W, MAN_W);
  assign sb   = fld_sign(64'(b_p0), EXP_W, MAN_W);
  assign ea   = EXP_W'(fld_exp(64'(a_p0), EXP_W, MAN_W));
  assign eb   = EXP_W'(fld_exp(64'(b_p0), EXP_W, MAN_W));
  assign fa   = MAN_W'(fld_man(64'(a_p0), MAN_W));
  assign fb   = MAN_W'(fld_man(64'(b_p0), MAN_W));
  assign za   = (ea == '0);
  assign zb   = (eb == '0);
  assign ma   = za ? '0 : {1'b1, fa};
  assign mb   = zb ? '0 : {1'b1, fb};
  assign ea_s = $signed(XW'(ea));
  assign eb_s = $signed(XW'(eb));
  // Hidden bit sits at W-2 so an addf carry lands in the top bit.
  assign ga   = W'(ma) << (W - 1 - MW);
  assign gb   = W'(mb) << (W - 1 - MW);

  assign in_ready = (state == S_IDLE);

  // ---- EXEC: raw magnitude/exponent, leading 1 expected near bit W-1 ----
  logic                   sign_x, byp_x, berr_x, a_big, s_hi, s_lo;
  logic signed [XW-1:0]   exp_x, sh, e_hi, d;
  logic [W-1:0]           mag_x, bval_x, ival, g_hi, g_lo, g_al;
  logic [W+MAN_W-1:0]     wide;
  logic [PW-1:0]          prod;
  logic [PW+W-1:0]        pwide;

  always_comb begin
    sign_x = 1'b0;
    exp_x  = '0;
    mag_x  = '0;
    byp_x  = 1'b1;
    bval_x = a_p0;
    berr_x = 1'b1;
    sh     = ea_s - BIAS_X;
    wide   = {{(W-1){1'b0}}, ma} << sh;
    ival   = W'(wide >> MAN_W);
    a_big  = (ea_s >= eb_s);
    e_hi   = a_big ? ea_s : eb_s;
    d      = a_big ? ea_s - eb_s : eb_s - ea_s;
    g_hi   = a_big ? ga : gb;
    g_lo   = a_big ? gb : ga;
    s_hi   = a_big ? sa : sb;
    s_lo   = a_big ? sb : sa;
    g_al   = (d >= W_X) ? '0 : g_lo >> d;
    prod   = PW'(ma) * PW'(mb);
    pwide  = {prod, {W{1'b0}}};
    case (op_p0)
      OP_I2F: begin
        byp_x  = 1'b0;
        sign_x = a_p0[W-1];
        mag_x  = a_p0[W-1] ? -a_p0 : a_p0;
        exp_x  = LIM_X;
      end
      OP_F2I: begin
        berr_x = 1'b0;
        if (za || ea_s < BIAS_X) begin
          bval_x = '0;
        end else if (ea_s >= LIM_X) begin
          bval_x = sa ? SAT_NEG : SAT_POS;
          berr_x = 1'b1;
        end else begin
          bval_x = sa ? -ival : ival;
        end
      end
      OP_ADDF: begin
        byp_x = 1'b0;
        exp_x = e_hi + ONE_X;
        if (s_hi == s_lo) begin
          mag_x  = g_hi + g_al;
          sign_x = s_hi;
        end else if (g_hi >= g_al) begin
          mag_x  = g_hi - g_al;
          sign_x = s_hi;
        end else begin
          mag_x  = g_al - g_hi;
          sign_x = s_lo;
        end
      end
      OP_MULF: begin
        byp_x  = 1'b0;
        sign_x = sa ^ sb;
        exp_x  = ea_s + eb_s - BIAS_X + ONE_X;
        mag_x  = (za || zb) ? '0 : W'(pwide >> PW);
      end
`ifdef FPU_INVF_EN
      OP_INVF: begin
        if (za) begin
          bval_x = {sa, {(W-1){1'b1}}};
        end else begin
          byp_x  = 1'b0;
          sign_x = sa;
          exp_x  = BIAS_X + BIAS_X - ea_s;
        end
      end
`endif
      default: ;
    endcase
  end

  logic                 sign_p1, byp_p1, berr_p1;
  logic signed [XW-1:0] exp_p1;
  logic [W-1:0]         mag_p1, bval_p1;

`ifdef FPU_INVF_EN
  localparam int QW = MAN_W + 2;
  localparam int CW = $clog2(QW + 1);
  logic [QW-1:0] rem_p1, q_p1, rem_sub, q_nx;
  logic [MW-1:0] dv_p1;
  logic [CW-1:0] cnt_p1;
  logic          ge;

  // ---- ITER: one restoring-division quotient bit of 1.0/(1.man) per cycle ----
  always_comb begin
    ge      = (rem_p1 >= QW'(dv_p1));
    rem_sub = ge ? rem_p1 - QW'(dv_p1) : rem_p1;
    q_nx    = (q_p1 << 1) | QW'(ge);
  end
`endif

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      op_p0 <= op;
      a_p0  <= in1;
      b_p0  <= in2;
    end
    if (state == S_EXEC) begin
      sign_p1 <= sign_x;
      exp_p1  <= exp_x;
      mag_p1  <= mag_x;
      byp_p1  <= byp_x;
      bval_p1 <= bval_x;
      berr_p1 <= berr_x;
`ifdef FPU_INVF_EN
      rem_p1  <= QW'(1) << MAN_W;
      dv_p1   <= ma;
      q_p1    <= '0;
      cnt_p1  <= '0;
`endif
    end
`ifdef FPU_INVF_EN
    else if (state == S_ITER) begin
      rem_p1 <= rem_sub << 1;
      q_p1   <= q_nx;
      cnt_p1 <= cnt_p1 + CW'(1);
      mag_p1 <= W'(q_nx) << (W - QW);
    end
`endif
  end

  // ---- NORM: left-justify, range-check and pack ----
  logic [LZW-1:0]       lz;
  logic [W-1:0]         shifted, res_n;
  logic signed [XW-1:0] en;
  logic                 err_n;

  fpu_mc_lzc #(.DATA_W(W)) u_lzc (
    .value (mag_p1),
    .count (lz)
  );

  always_comb begin
    shifted = mag_p1 << lz;
    en      = exp_p1 - $signed({{(XW-LZW){1'b0}}, lz});
    res_n   = '0;
    err_n   = 1'b0;
    if (byp_p1) begin
      res_n = bval_p1;
      err_n = berr_p1;
    end else if (mag_p1 == '0) begin
      res_n = '0;
    end else if (en > EMAX_X) begin
      res_n = {sign_p1, {(W-1){1'b1}}};
      err_n = 1'b1;
    end else if (en >= ONE_X) begin
      res_n = {sign_p1, EXP_W'(en), MAN_W'(shifted >> (W - 1 - MAN_W))};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_NORM;
`ifdef FPU_INVF_EN
        if (op_p0 == OP_INVF) state_nx = S_ITER;
`endif
      end
`ifdef FPU_INVF_EN
      S_ITER: if (cnt_p1 == CW'(QW - 1)) state_nx = S_NORM;
`endif
      S_NORM: state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_NORM) begin
        out_valid <= 1'b1;
        result    <= res_n;
        err       <= err_n;
      end else if (state == S_DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fpu_mc.sv
// Directed bench for fpu_mc (default 1/8/7 format); invf expectations follow FPU_INVF_EN.
module tb_fpu_mc;
  import fpu_pkg::*;

  localparam int W = 16;

`ifdef FPU_INVF_EN
  localparam int         LAT_INV  = 12;
  localparam logic [W-1:0] INV2_RES = 16'h3F00;
  localparam logic       INV2_ERR = 1'b0;
  localparam logic [W-1:0] INV0_RES = 16'h7FFF;
`else
  localparam int         LAT_INV  = 3;
  localparam logic [W-1:0] INV2_RES = 16'h4000;
  localparam logic       INV2_ERR = 1'b1;
  localparam logic [W-1:0] INV0_RES = 16'h0000;
`endif

  logic         clk = 1'b0;
  logic         reset_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]   op;
  logic [W-1:0] in1, in2, result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_mc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] want_res,
                     input logic want_err, input int want_lat);
    int lat;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk({tag, "_res"}, 32'(result), 32'(want_res));
    chk({tag, "_err"}, 32'(err), 32'(want_err));
    chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    vec("i2f_5",     OP_I2F, 16'h0005, 16'h0000, 16'h40A0, 1'b0, 3);
    vec("i2f_m1",    OP_I2F, 16'hFFFF, 16'h0000, 16'hBF80, 1'b0, 3);
    vec("i2f_min",   OP_I2F, 16'h8000, 16'h0000, 16'hC700, 1'b0, 3);
    vec("i2f_0",     OP_I2F, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3);
    vec("f2i_5",     OP_F2I, 16'h40A0, 16'h0000, 16'h0005, 1'b0, 3);
    vec("f2i_half",  OP_F2I, 16'h3F00, 16'h0000, 16'h0000, 1'b0, 3);
    vec("f2i_sat",   OP_F2I, 16'h4780, 16'h0000, 16'h7FFF, 1'b1, 3);
    vec("addf_1p2",  OP_ADDF, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 3);
    vec("addf_canc", OP_ADDF, 16'h3F80, 16'hBF80, 16'h0000, 1'b0, 3);
    vec("addf_ovf",  OP_ADDF, 16'h7F80, 16'h7F80, 16'h7FFF, 1'b1, 3);
    vec("mulf_1p5",  OP_MULF, 16'h4040, 16'h3F00, 16'h3FC0, 1'b0, 3);
    vec("mulf_zero", OP_MULF, 16'h0000, 16'h4040, 16'h0000, 1'b0, 3);
    vec("invf_2",    OP_INVF, 16'h4000, 16'h0000, INV2_RES, INV2_ERR, LAT_INV);
    vec("invf_0",    OP_INVF, 16'h0000, 16'h0000, INV0_RES, 1'b1, LAT_INV);
    vec("bad_op",    4'h7, 16'h1234, 16'h5678, 16'h1234, 1'b1, 3);

    // Backpressure with a second op pending on the input side.
    op = OP_I2F; in1 = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 16'h0003;
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_res", 32'(result), 32'h40A0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", 32'(in_ready), 32'd0);
    wait_out(lat);
    chk("bp_next_res", 32'(result), 32'h4040);
    chk("bp_next_lat", 32'(lat), 32'd3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while the op is still in progress.
    op = OP_INVF; in1 = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", 32'(result), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    vec("post_rst", OP_ADDF, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_mc.md
Name: fpu_mc

Overview:
- Multi-cycle, parametrised floating-point unit; successor to the combinational ALU float path.
- Executes i2f, f2i, addf, mulf and invf on a sign/exponent/mantissa format (default 1/8/7, bias 127).
- Uses valid/ready handshakes on input and output, with one operation in flight.
- Sits beside the integer ALU in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 7, stored mantissa width (hidden 1 implied); word width W = 1+EXP_W+MAN_W
BIAS, 2**(EXP_W-1)-1, exponent bias

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept (high only in IDLE)
op  in  4  opcode, shared values: invf=1, addf=2, mulf=3, f2i=0xA, i2f=0xB
in1  in  W  operand 1 (int for i2f, float otherwise)
in2  in  W  operand 2 (addf/mulf only)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  W  result word
err  out  1  qualifies result: illegal op, divide-by-zero or saturation

Behaviour:
- Reset: synchronous on clk edge with reset_n=0. Values: state=IDLE, in_ready=1, out_valid=0, result=0, err=0. Reset mid-operation abandons the op silently.
- Accept: on an edge with in_valid&in_ready, op/in1/in2 are latched. in_ready drops until the result handshake completes.
- FSM:
  - IDLE->EXEC on accept.
  - EXEC->NORM for non-invf ops; EXEC->ITER for invf.
  - ITER runs MAN_W+2 cycles (restoring divide), then ->NORM.
  - NORM->DONE.
  - DONE->IDLE on out_ready.
- Latency: out_valid rises 3 edges after accept (invf: MAN_W+5). in_ready returns 1 the cycle after the output handshake; no accept happens in the same edge as the output handshake.
- Backpressure: result/err stay stable while out_valid&!out_ready.
- Float rules:
  - exp==0 means zero; denormals flush to signed zero on input, +0 on output.
  - No Inf/NaN: all nonzero exponents are normal. Overflow saturates to sign|max magnitude (0x7FFF/0xFFFF default) with err=1. Underflow gives +0, err=0.
  - Rounding: truncation toward zero throughout.
- i2f:
  - Sign from in1[W-1], magnitude = two's-complement abs.
  - lz = leading zeros; exp = BIAS+(W-1)-lz; mantissa = next MAN_W bits below the leading 1.
  - in1==0 gives 0. Most-negative int gives sign=1, exp=BIAS+W-1, man=0.
- f2i:
  - exp<BIAS gives 0.
  - exp>=BIAS+W-1 saturates to 0x7FFF / 0x8000 (by sign) with err=1.
  - Otherwise (1.man) is shifted by exp-BIAS, truncated, and negated if sign set.
- addf:
  - Align the smaller exponent (shifted-out bits discarded), add/subtract magnitudes, renormalise via lzc.
  - Exact cancellation gives +0.
- mulf: exp = e1+e2-BIAS, product of (1.man) pairs normalised by at most one shift; either operand zero gives +0.
- invf: 1/in1 via restoring division of 1.0 by (1.man); exp = 2*BIAS-e (adjusted on normalise). in1 zero gives 0x7FFF|sign with err=1.
- Unlisted op: result=in1, err=1, using the normal 3-cycle latency.

Optional Feature:
- FPU_INVF_EN defined: invf implemented as above; ITER state and divider present.
- Undefined: divider and ITER state omitted. invf is treated as an unlisted op (result=in1, err=1, latency 3).

Decomposition:
- Shared package fpu_pkg: opcode constants (reuses ISA values), default EXP_W/MAN_W/BIAS, FSM state enum, and field-slice helper functions for sign/exp/man.
- One natural sub-module: lzc, a parametrised leading-zero counter (width W, output $clog2(W)+1 bits, all-zero input returns W). Used by i2f and by addf normalisation.

Test Plan:
- i2f in1=0x0005 -> result 0x40A0, err=0, out_valid 3 cycles after accept. in1=0xFFFF -> 0xBF80. in1=0x8000 -> 0xC700.
- f2i in1=0x40A0 -> 0x0005. in1=0x3F00 (0.5) -> 0x0000. in1=0x4780 (65536.0) -> 0x7FFF, err=1.
- addf 0x3F80+0x4000 -> 0x4040. addf 0x3F80+0xBF80 -> 0x0000. mulf 0x4040*0x3F00 -> 0x3FC0.
- invf 0x4000 -> 0x3F00 at latency MAN_W+5=12. invf 0x0000 -> 0x7FFF, err=1. Repeat with FPU_INVF_EN undefined -> result=in1, err=1, latency 3.
- Backpressure: out_ready held low 5 cycles -> result stable, in_ready=0, a pending in_valid is not accepted. On out_ready the next op is accepted the following edge.
- reset_n low during ITER -> next edge out_valid=0, in_ready=1, result=0. A new op then completes normally.
